// File: rtl/natalius_imem_loader_if.sv
// Byte-stream and SRAM port-0 bundle for the instruction memory loader.
//   byte_valid/byte_data/byte_ready : host byte stream, valid/ready handshake
//   csb0/web0/wmask0/addr0/din0     : SRAM port 0 request pins (driven by the loader)
//   dout0                           : SRAM port 0 read data
// modport master : the loader side; modport slave : the host/SRAM side.
interface natalius_imem_loader_if #(
  parameter int unsigned ADDR_W = 11
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              csb0;
  logic              web0;
  logic [1:0]        wmask0;
  logic [ADDR_W-1:0] addr0;
  logic [15:0]       din0;
  logic [15:0]       dout0;

  modport master (
    input  byte_valid, byte_data, dout0,
    output byte_ready, csb0, web0, wmask0, addr0, din0
  );

  modport slave (
    output byte_valid, byte_data, dout0,
    input  byte_ready, csb0, web0, wmask0, addr0, din0
  );
endinterface

// File: rtl/natalius_imem_loader.sv
// Boot-time loader: assembles little-endian 16-bit words from a byte stream and
// writes them to consecutive addresses of SRAM port 0 while holding the CPU in reset.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start           : one-cycle load request (ignored while busy)
//   base_addr       : first word address, sampled on start
//   word_count      : words to load, sampled on start, clamped to 2^ADDR_W
//   bus (master)    : byte stream handshake + SRAM port 0 pins
//   cpu_rst         : processor reset, held during a load
//   busy, done      : load in progress / one-cycle completion pulse
//   err             : sticky read-back mismatch flag
//   checksum        : mod-2^16 sum of words written in the current load
// Optional read-back verify of every word: define NATALIUS_LOADER_VERIFY_EN.
module natalius_imem_loader #(
  parameter int unsigned ADDR_W        = 11,
  parameter int unsigned READ_LAT      = 2,
  parameter bit          HOLD_AT_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W:0]      word_count,
  natalius_imem_loader_if.master bus,
  output logic                 cpu_rst,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [15:0]          checksum
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_LO, S_HI, S_WR, S_VRD, S_VWT, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [15:0]       word_q, word_d;
  logic [15:0]       checksum_q, checksum_d;
  logic              err_q, err_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              byte_ready_q, byte_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              csb0_q, csb0_d;
  logic              web0_q, web0_d;
  logic [1:0]        wmask0_q, wmask0_d;
  logic [ADDR_W-1:0] addr0_q, addr0_d;
  logic [15:0]       din0_q, din0_d;
  logic [CNT_W-1:0]  words_c;
  logic              advance_c;
  logic              byte_hs_c;

`ifdef NATALIUS_LOADER_VERIFY_EN
  localparam int unsigned WAIT_W = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
`else
  logic unused_dout0_c;
  assign unused_dout0_c = ^bus.dout0;
`endif

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      word_q       <= '0;
      checksum_q   <= '0;
      err_q        <= 1'b0;
      cpu_rst_q    <= HOLD_AT_RESET;
      byte_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      csb0_q       <= 1'b1;
      web0_q       <= 1'b1;
      wmask0_q     <= 2'b00;
      addr0_q      <= '0;
      din0_q       <= '0;
`ifdef NATALIUS_LOADER_VERIFY_EN
      wait_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      word_q       <= word_d;
      checksum_q   <= checksum_d;
      err_q        <= err_d;
      cpu_rst_q    <= cpu_rst_d;
      byte_ready_q <= byte_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      csb0_q       <= csb0_d;
      web0_q       <= web0_d;
      wmask0_q     <= wmask0_d;
      addr0_q      <= addr0_d;
      din0_q       <= din0_d;
`ifdef NATALIUS_LOADER_VERIFY_EN
      wait_q       <= wait_d;
`endif
    end
  end

  assign words_c   = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
  // byte_ready_q is high exactly while the FSM sits in LO or HI
  assign byte_hs_c = bus.byte_valid & byte_ready_q;

  // Next state, datapath and next values of every registered output
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    word_d      = word_q;
    checksum_d  = checksum_q;
    err_d       = err_q;
    cpu_rst_d   = cpu_rst_q;
    advance_c   = 1'b0;
`ifdef NATALIUS_LOADER_VERIFY_EN
    wait_d      = wait_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          remaining_d = words_c;
          checksum_d  = '0;
          err_d       = 1'b0;
          cpu_rst_d   = 1'b1;
          state_d     = (words_c == '0) ? S_DONE : S_LO;
        end
      end
      S_LO: begin
        if (byte_hs_c) begin
          word_d[7:0] = bus.byte_data;
          state_d     = S_HI;
        end
      end
      S_HI: begin
        if (byte_hs_c) begin
          word_d[15:8] = bus.byte_data;
          state_d      = S_WR;
        end
      end
      S_WR: begin
        checksum_d = checksum_q + word_q;
`ifdef NATALIUS_LOADER_VERIFY_EN
        state_d    = S_VRD;
`else
        advance_c  = 1'b1;
`endif
      end
`ifdef NATALIUS_LOADER_VERIFY_EN
      S_VRD: begin
        wait_d  = '0;
        state_d = S_VWT;
      end
      S_VWT: begin
        // Compare one cycle after dout0 is guaranteed valid
        if (wait_q == WAIT_W'(READ_LAT)) begin
          if (bus.dout0 == word_q) begin
            advance_c = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Word committed: step address (wraps naturally) and count
    if (advance_c) begin
      addr_d      = addr_q + ADDR_W'(1);
      remaining_d = remaining_q - CNT_W'(1);
      state_d     = (remaining_q == CNT_W'(1)) ? S_DONE : S_LO;
    end

    // Release the CPU on completion unless verify failed
    if (state_d == S_DONE) begin
      cpu_rst_d = err_d;
    end

    byte_ready_d = (state_d == S_LO) || (state_d == S_HI);
    busy_d       = (state_d == S_LO) || (state_d == S_HI) || (state_d == S_WR) ||
                   (state_d == S_VRD) || (state_d == S_VWT);
    done_d       = (state_d == S_DONE);

    csb0_d   = 1'b1;
    web0_d   = 1'b1;
    wmask0_d = 2'b00;
    addr0_d  = addr0_q;
    din0_d   = din0_q;
    if (state_d == S_WR) begin
      csb0_d   = 1'b0;
      web0_d   = 1'b0;
      wmask0_d = 2'b11;
      addr0_d  = addr_d;
      din0_d   = word_d;
    end else if (state_d == S_VRD) begin
      csb0_d  = 1'b0;
      addr0_d = addr_d;
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.csb0       = csb0_q;
  assign bus.web0       = web0_q;
  assign bus.wmask0     = wmask0_q;
  assign bus.addr0      = addr0_q;
  assign bus.din0       = din0_q;
  assign cpu_rst        = cpu_rst_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign checksum       = checksum_q;

endmodule

// File: tb/tb_natalius_imem_loader.sv
// Self-checking bench for natalius_imem_loader: table vectors, randomized loads
// against a word-list reference model, reset abort, clamp and (optional) verify.
module tb_natalius_imem_loader;
  localparam int unsigned ADDR_W   = 11;
  localparam int unsigned READ_LAT = 2;
  localparam int          DEPTH    = 2 ** ADDR_W;
`ifdef NATALIUS_LOADER_VERIFY_EN
  localparam int          CPW      = 5 + READ_LAT;
`else
  localparam int          CPW      = 3;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic              cpu_rst, busy, done, err;
  logic [15:0]       checksum;

  int checks = 0;
  int errors = 0;

  natalius_imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  natalius_imem_loader #(
    .ADDR_W(ADDR_W), .READ_LAT(READ_LAT), .HOLD_AT_RESET(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .bus(bus), .cpu_rst(cpu_rst), .busy(busy),
    .done(done), .err(err), .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Byte source: holds an unaccepted byte, optionally inserts random gaps
  logic [7:0] src_q[$];
  bit         gaps_en = 1'b0;
  bit         src_acc;
  int         acc_cnt = 0;
  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    forever begin
      @(posedge clk);
      src_acc = bus.byte_valid && bus.byte_ready && !rst;
      if (src_acc) begin
        acc_cnt++;
        if (src_q.size() > 0) void'(src_q.pop_front());
      end
      #1;
      if (bus.byte_valid && !src_acc) begin
        // hold
      end else if (src_q.size() > 0 && (!gaps_en || $urandom_range(0, 1) == 1)) begin
        bus.byte_valid = 1'b1;
        bus.byte_data  = src_q[0];
      end else begin
        bus.byte_valid = 1'b0;
      end
    end
  end

  // SRAM model and write/read monitor
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
    logic [1:0]        mask;
  } wr_t;
  wr_t               wr_q[$];
  logic [15:0]       mem [DEPTH];
  logic [15:0]       rd_pipe [READ_LAT];
  int                rd_cnt = 0;
  logic [ADDR_W-1:0] last_rd_addr = '0;
  bit                corrupt_en = 1'b0;
  initial begin
    wr_t w;
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0000;
    for (int i = 0; i < int'(READ_LAT); i++) rd_pipe[i] = 16'h0000;
    bus.dout0 <= 16'h0000;
    forever begin
      @(posedge clk);
      for (int i = int'(READ_LAT) - 1; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
      if (!rst && !bus.csb0 && !bus.web0) begin
        w.addr = bus.addr0; w.data = bus.din0; w.mask = bus.wmask0;
        wr_q.push_back(w);
        mem[bus.addr0] = (corrupt_en && bus.addr0 == ADDR_W'(2)) ? (bus.din0 ^ 16'h0001) : bus.din0;
      end else if (!rst && !bus.csb0 && bus.web0) begin
        rd_cnt++;
        last_rd_addr = bus.addr0;
        rd_pipe[0]   = mem[bus.addr0];
      end
      bus.dout0 <= rd_pipe[READ_LAT-1];
    end
  end

  // One load, checked against a model built from the word list the bytes describe
  task automatic run_load(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] cnt,
                          input logic [7:0] bytes[$], input bit gaps, input bit mid_start,
                          input int bad_idx, output logic [15:0] cs_out, output int nwr_out,
                          output logic [ADDR_W-1:0] first_a, output logic [ADDR_W-1:0] last_a);
    int n, n_exp, lat, budget, nbad;
    bit seen;
    logic [15:0] exp_cs, w;
    logic [ADDR_W-1:0] ea;
    n      = (int'(cnt) > DEPTH) ? DEPTH : int'(cnt);
    n_exp  = (bad_idx >= 0) ? bad_idx + 1 : n;
    exp_cs = 16'h0000;
    for (int i = 0; i < n_exp; i++) exp_cs = exp_cs + {bytes[2*i+1], bytes[2*i]};
    wr_q.delete();
    src_q = bytes;
    src_q.push_back(8'hA5);
    src_q.push_back(8'h5A);
    gaps_en = gaps;
    @(negedge clk);
    start = 1'b1; base_addr = base; word_count = cnt;
    @(negedge clk);
    start = 1'b0;
    if (n > 0) begin
      check("cpu_rst_on_start", 32'(cpu_rst), 32'(1));
      check("busy_on_start", 32'(busy), 32'(1));
    end
    budget = n * CPW * 6 + 20;
    lat = 1; seen = 1'b0;
    while (lat <= budget) begin
      if (done === 1'b1) begin seen = 1'b1; break; end
      start = mid_start && (lat == 4);
      base_addr = ADDR_W'(11'h555); word_count = 12'd7;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("done_seen", 32'(seen), 32'(1));
    cs_out = checksum;
    if (seen) begin
      if (!gaps && bad_idx < 0) check("latency", 32'(lat), 32'(n * CPW + 1));
      check("busy_at_done", 32'(busy), 32'(0));
      check("checksum_at_done", 32'(checksum), 32'(exp_cs));
      check("cpu_rst_at_done", 32'(cpu_rst), 32'(bad_idx >= 0));
      check("err_at_done", 32'(err), 32'(bad_idx >= 0));
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'(0));
    end
    check("write_count", 32'(wr_q.size()), 32'(n_exp));
    nbad = 0;
    for (int i = 0; i < wr_q.size() && i < n_exp; i++) begin
      ea = ADDR_W'((int'(base) + i) % DEPTH);
      w  = {bytes[2*i+1], bytes[2*i]};
      if (wr_q[i].addr !== ea || wr_q[i].data !== w || wr_q[i].mask !== 2'b11) nbad++;
    end
    check("write_stream_bad", 32'(nbad), 32'(0));
    check("bytes_left", 32'(src_q.size()), 32'(2 + 2 * (n - n_exp)));
    nwr_out = wr_q.size();
    first_a = (wr_q.size() > 0) ? wr_q[0].addr : '0;
    last_a  = (wr_q.size() > 0) ? wr_q[wr_q.size()-1].addr : '0;
    src_q.delete();
    bus.byte_valid = 1'b0;
    @(negedge clk);
  endtask

  // Table: bytes packed with the first stream byte in the least significant position
  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   cnt;
    logic [63:0]       bytes;
    logic [15:0]       exp_cs;
    int                exp_nwr;
    logic [ADDR_W-1:0] exp_first;
    logic [ADDR_W-1:0] exp_last;
  } vec_t;
  vec_t vecs [5];

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]        bq[$];
    logic [15:0]       cs;
    int                nwr, a0, k, rd0;
    logic [ADDR_W-1:0] fa, la;

    vecs[0] = '{11'h010, 12'd4, 64'hDEF0_9ABC_5678_1234, 16'hE258, 4, 11'h010, 11'h013};
    vecs[1] = '{11'h7FF, 12'd2, 64'h0000_0000_0002_0001, 16'h0003, 2, 11'h7FF, 11'h000};
    vecs[2] = '{11'h123, 12'd0, 64'h0000_0000_0000_0000, 16'h0000, 0, 11'h000, 11'h000};
    vecs[3] = '{11'h100, 12'd1, 64'h0000_0000_0000_FFFF, 16'hFFFF, 1, 11'h100, 11'h100};
    vecs[4] = '{11'h003, 12'd3, 64'h0000_8000_7FFF_8001, 16'h8000, 3, 11'h003, 11'h005};

    rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
    repeat (3) @(negedge clk);
    check("rst_csb0", 32'(bus.csb0), 32'(1));
    check("rst_web0", 32'(bus.web0), 32'(1));
    check("rst_wmask0", 32'(bus.wmask0), 32'(0));
    check("rst_addr0", 32'(bus.addr0), 32'(0));
    check("rst_din0", 32'(bus.din0), 32'(0));
    check("rst_byte_ready", 32'(bus.byte_ready), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_checksum", 32'(checksum), 32'(0));
    check("rst_cpu_rst", 32'(cpu_rst), 32'(1));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("cpu_rst_held_after_rst", 32'(cpu_rst), 32'(1));

    // Table-driven loads, bytes back to back
    for (int v = 0; v < 5; v++) begin
      bq.delete();
      for (int i = 0; i < 2 * int'(vecs[v].cnt); i++) bq.push_back(vecs[v].bytes[8*i +: 8]);
      run_load(vecs[v].base, vecs[v].cnt, bq, 1'b0, 1'b0, -1, cs, nwr, fa, la);
      check($sformatf("vec%0d_checksum", v), 32'(cs), 32'(vecs[v].exp_cs));
      check($sformatf("vec%0d_nwr", v), 32'(nwr), 32'(vecs[v].exp_nwr));
      if (vecs[v].exp_nwr > 0) begin
        check($sformatf("vec%0d_first_addr", v), 32'(fa), 32'(vecs[v].exp_first));
        check($sformatf("vec%0d_last_addr", v), 32'(la), 32'(vecs[v].exp_last));
      end
    end

    // Reset after the first byte of word 3 aborts the load
    bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    src_q = bq; gaps_en = 1'b0; wr_q.delete(); a0 = acc_cnt;
    @(negedge clk);
    start = 1'b1; base_addr = 11'h020; word_count = 12'd4;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while ((acc_cnt - a0) < 5 && k < 100) begin @(negedge clk); k++; end
    check("abort_bytes_reached", 32'(acc_cnt - a0), 32'(5));
    rst = 1'b1;
    #1;
    check("abort_csb0", 32'(bus.csb0), 32'(1));
    check("abort_web0", 32'(bus.web0), 32'(1));
    check("abort_wmask0", 32'(bus.wmask0), 32'(0));
    check("abort_addr0", 32'(bus.addr0), 32'(0));
    check("abort_byte_ready", 32'(bus.byte_ready), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_checksum", 32'(checksum), 32'(0));
    check("abort_cpu_rst", 32'(cpu_rst), 32'(1));
    check("abort_writes_before", 32'(wr_q.size()), 32'(2));
    src_q.delete();
    bus.byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_no_more_writes", 32'(wr_q.size()), 32'(2));
    check("abort_idle_busy", 32'(busy), 32'(0));
    check("abort_idle_done", 32'(done), 32'(0));

    // Randomized loads with ragged byte_valid and stray starts
    for (int r = 0; r < 6; r++) begin
      logic [ADDR_W-1:0] rb;
      logic [ADDR_W:0]   rc;
      rb = ADDR_W'($urandom_range(0, DEPTH - 1));
      rc = (ADDR_W+1)'($urandom_range(2, 10));
      bq.delete();
      for (int i = 0; i < 2 * int'(rc); i++) bq.push_back(8'($urandom_range(0, 255)));
      run_load(rb, rc, bq, 1'b1, (r % 2) == 1, -1, cs, nwr, fa, la);
    end

    // Oversized word_count clamps to the full array and wraps the address
    bq.delete();
    for (int i = 0; i < 2 * DEPTH; i++) bq.push_back(8'($urandom_range(0, 255)));
    run_load(11'h400, 12'd2053, bq, 1'b0, 1'b0, -1, cs, nwr, fa, la);
    check("clamp_nwr", 32'(nwr), 32'(DEPTH));
    check("clamp_last_addr", 32'(la), 32'(11'h3FF));

`ifdef NATALIUS_LOADER_VERIFY_EN
    // Corrupted bit 0 at address 0x002 stops the load after that read
    corrupt_en = 1'b1;
    rd0 = rd_cnt;
    bq.delete();
    for (int i = 0; i < 10; i++) bq.push_back(8'($urandom_range(0, 255)));
    run_load(11'h000, 12'd5, bq, 1'b0, 1'b0, 2, cs, nwr, fa, la);
    check("verify_nwr", 32'(nwr), 32'(3));
    check("verify_last_write", 32'(la), 32'(2));
    check("verify_last_read", 32'(last_rd_addr), 32'(2));
    check("verify_reads", 32'(rd_cnt - rd0), 32'(3));
    check("verify_err_sticky", 32'(err), 32'(1));
    check("verify_cpu_rst_held", 32'(cpu_rst), 32'(1));
    corrupt_en = 1'b0;
`else
    rd0 = rd_cnt;
    check("no_reads_without_verify", 32'(rd0), 32'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
